// File: rtl/conv_layer_pkg.sv
// Shared codes and default geometry for the convolution layer input side.
// Command/ack encodings, FSM state encoding, and default parameter values.
package conv_layer_pkg;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_KERNEL_SIZE = 3;
    localparam int DEF_IMAGE_SIZE  = 8;
    localparam int DEF_ARRAY_SIZE  = DEF_IMAGE_SIZE - DEF_KERNEL_SIZE + 1;
    localparam int DEF_ADDR_WIDTH  = 6;

    localparam logic [1:0] CMD_IDLE          = 2'd0;
    localparam logic [1:0] CMD_PRELOAD_START = 2'd1;
    localparam logic [1:0] CMD_SHIFT_START   = 2'd2;
    localparam logic [1:0] CMD_LOAD_START    = 2'd3;

    localparam logic [1:0] ACK_IDLE        = 2'd0;
    localparam logic [1:0] ACK_PRELOAD_FIN = 2'd1;
    localparam logic [1:0] ACK_SHIFT_FIN   = 2'd2;
    localparam logic [1:0] ACK_LOAD_FIN    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    // Each finished command answers with the ack code of the same value.
    function automatic logic [1:0] ack_for_cmd(input logic [1:0] cmd);
        unique case (cmd)
            CMD_PRELOAD_START: ack_for_cmd = ACK_PRELOAD_FIN;
            CMD_SHIFT_START:   ack_for_cmd = ACK_SHIFT_FIN;
            CMD_LOAD_START:    ack_for_cmd = ACK_LOAD_FIN;
            default:           ack_for_cmd = ACK_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/conv_row_buffer.sv
// One image row of pixel storage with a single write port and an
// offset-selected ARRAY_SIZE-wide window onto it.
module conv_row_buffer
    import conv_layer_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int IMAGE_SIZE  = DEF_IMAGE_SIZE,
    parameter int ARRAY_SIZE  = DEF_ARRAY_SIZE,
    parameter int COL_W       = $clog2(DEF_IMAGE_SIZE),
    parameter int OFS_W       = $clog2(DEF_KERNEL_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        we,
    input  logic [COL_W-1:0]            wr_col,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic [OFS_W-1:0]            offset,
    output logic [ARRAY_SIZE*WIDTH-1:0] window_data
);

    logic [WIDTH-1:0] buf_q [IMAGE_SIZE];
    logic [WIDTH-1:0] buf_d [IMAGE_SIZE];

    always_comb begin
        buf_d = buf_q;
        if (we && (int'(wr_col) < IMAGE_SIZE)) begin
            buf_d[wr_col] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IMAGE_SIZE; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            buf_q <= buf_d;
        end
    end

    // Offsets never push the window past the row end with legal geometry.
    always_comb begin
        window_data = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            if ((int'(offset) + i) < IMAGE_SIZE) begin
                window_data[i*WIDTH +: WIDTH] = buf_q[int'(offset) + i];
            end
        end
    end

endmodule

// File: rtl/conv_input_interface.sv
// Responder for the conv layer input command/ack protocol: fetches image rows
// from ROM into a row buffer and presents a shifted window. Optional cmd_err
// output is enabled by defining CONV_INPUT_IF_CMD_ERR_EN.
module conv_input_interface
    import conv_layer_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int IMAGE_SIZE  = DEF_IMAGE_SIZE,
    parameter int ARRAY_SIZE  = DEF_ARRAY_SIZE,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  input_interface_cmd,
    output logic [1:0]                  input_interface_ack,
    output logic                        rom_rd_en,
    output logic [ADDR_WIDTH-1:0]       rom_addr,
    input  logic [WIDTH-1:0]            rom_data,
    output logic [ARRAY_SIZE*WIDTH-1:0] window_data,
    output logic                        window_valid,
    output logic                        frame_done,
`ifdef CONV_INPUT_IF_CMD_ERR_EN
    output logic                        cmd_err,
`endif
    output logic [1:0]                  dbg_state
);

    localparam int ROW_W = $clog2(IMAGE_SIZE);
    localparam int COL_W = $clog2(IMAGE_SIZE);
    localparam int OFS_W = $clog2(KERNEL_SIZE);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_SIZE - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_SIZE - 1);
    localparam logic [OFS_W-1:0] OFS_LAST = OFS_W'(KERNEL_SIZE - 1);

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [OFS_W-1:0]   offset_q, offset_d;
    logic [COL_W-1:0]   rd_col_q, rd_col_d;
    logic [COL_W-1:0]   wr_col_q, wr_col_d;
    logic               wr_en_q, wr_en_d;
    logic [1:0]         cur_cmd_q, cur_cmd_d;
    logic [1:0]         ack_q, ack_d;
    logic               valid_q, valid_d;
    logic               frame_done_q, frame_done_d;
`ifdef CONV_INPUT_IF_CMD_ERR_EN
    logic               preloaded_q, preloaded_d;
    logic               cmd_err_q, cmd_err_d;
`endif

    logic in_idle;
    assign in_idle = (state_q == S_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (input_interface_cmd == CMD_PRELOAD_START ||
                    input_interface_cmd == CMD_LOAD_START) begin
                    state_d = S_FETCH;
                end else if (input_interface_cmd == CMD_SHIFT_START) begin
                    state_d = S_ACK;
                end
            end
            S_FETCH: if (rd_col_q == COL_LAST) state_d = S_DRAIN;
            S_DRAIN: state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output logic
    always_comb begin
        row_d        = row_q;
        offset_d     = offset_q;
        rd_col_d     = rd_col_q;
        cur_cmd_d    = cur_cmd_q;
        valid_d      = valid_q;
        frame_done_d = 1'b0;
        wr_en_d      = (state_q == S_FETCH);
        wr_col_d     = rd_col_q;

        if (in_idle) begin
            unique case (input_interface_cmd)
                CMD_PRELOAD_START: begin
                    row_d     = '0;
                    offset_d  = '0;
                    rd_col_d  = '0;
                    valid_d   = 1'b0;
                    cur_cmd_d = input_interface_cmd;
                end
                CMD_LOAD_START: begin
                    row_d        = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    frame_done_d = (row_q == ROW_LAST);
                    offset_d     = '0;
                    rd_col_d     = '0;
                    valid_d      = 1'b0;
                    cur_cmd_d    = input_interface_cmd;
                end
                CMD_SHIFT_START: begin
                    offset_d  = (offset_q == OFS_LAST) ? '0 : offset_q + 1'b1;
                    cur_cmd_d = input_interface_cmd;
                end
                default: ;
            endcase
        end

        if (state_q == S_FETCH) begin
            rd_col_d = (rd_col_q == COL_LAST) ? '0 : rd_col_q + 1'b1;
        end

        // The final word lands in the buffer at the end of the drain cycle.
        if (state_q == S_DRAIN) begin
            valid_d = 1'b1;
        end

        ack_d = (state_d == S_ACK) ? ack_for_cmd(cur_cmd_d) : ACK_IDLE;
    end

`ifdef CONV_INPUT_IF_CMD_ERR_EN
    always_comb begin
        preloaded_d = preloaded_q;
        cmd_err_d   = 1'b0;
        if (!in_idle && input_interface_cmd != CMD_IDLE) begin
            cmd_err_d = 1'b1;
        end
        if (in_idle && !preloaded_q &&
            (input_interface_cmd == CMD_SHIFT_START ||
             input_interface_cmd == CMD_LOAD_START)) begin
            cmd_err_d = 1'b1;
        end
        if (in_idle && input_interface_cmd == CMD_PRELOAD_START) begin
            preloaded_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preloaded_q <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            preloaded_q <= preloaded_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign cmd_err = cmd_err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q        <= '0;
            offset_q     <= '0;
            rd_col_q     <= '0;
            wr_col_q     <= '0;
            wr_en_q      <= 1'b0;
            cur_cmd_q    <= CMD_IDLE;
            ack_q        <= ACK_IDLE;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            row_q        <= row_d;
            offset_q     <= offset_d;
            rd_col_q     <= rd_col_d;
            wr_col_q     <= wr_col_d;
            wr_en_q      <= wr_en_d;
            cur_cmd_q    <= cur_cmd_d;
            ack_q        <= ack_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rom_rd_en           = (state_q == S_FETCH);
    assign rom_addr            = rom_rd_en ?
                                 (ADDR_WIDTH'(row_q) * ADDR_WIDTH'(IMAGE_SIZE) +
                                  ADDR_WIDTH'(rd_col_q)) : '0;
    assign input_interface_ack = ack_q;
    assign window_valid        = valid_q;
    assign frame_done          = frame_done_q;
    assign dbg_state           = state_q;

    conv_row_buffer #(
        .WIDTH      (WIDTH),
        .IMAGE_SIZE (IMAGE_SIZE),
        .ARRAY_SIZE (ARRAY_SIZE),
        .COL_W      (COL_W),
        .OFS_W      (OFS_W)
    ) u_row_buffer (
        .clk         (clk),
        .rst_n       (rst_n),
        .we          (wr_en_q),
        .wr_col      (wr_col_q),
        .wr_data     (rom_data),
        .offset      (offset_q),
        .window_data (window_data)
    );

endmodule

// File: tb/tb_conv_input_interface.sv
// Directed bench for conv_input_interface: preload, shifts, row loads with
// frame wrap, ignored mid-fetch command, and reset during a fetch.
module tb_conv_input_interface;

    localparam int W  = 32;
    localparam int IS = 8;
    localparam int AS = 6;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    cmd = 2'd0;
    logic [1:0]    ack;
    logic          rom_rd_en;
    logic [AW-1:0] rom_addr;
    logic [W-1:0]  rom_data = '0;
    logic [AS*W-1:0] window_data;
    logic          window_valid;
    logic          frame_done;
    logic [1:0]    dbg_state;
`ifdef CONV_INPUT_IF_CMD_ERR_EN
    logic          cmd_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    conv_input_interface dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .input_interface_cmd (cmd),
        .input_interface_ack (ack),
        .rom_rd_en           (rom_rd_en),
        .rom_addr            (rom_addr),
        .rom_data            (rom_data),
        .window_data         (window_data),
        .window_valid        (window_valid),
        .frame_done          (frame_done),
`ifdef CONV_INPUT_IF_CMD_ERR_EN
        .cmd_err             (cmd_err),
`endif
        .dbg_state           (dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // ROM model: each word equals its address, one cycle read latency.
    always @(posedge clk) begin
        if (rom_rd_en) rom_data <= 32'(rom_addr);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_window(input string tag, input int base, input bit zero);
        for (int i = 0; i < AS; i++) begin
            check(tag, 64'(window_data[i*W +: W]), zero ? 64'd0 : 64'(base + i));
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ack"}, 64'(ack), 64'd0);
        check({tag, "_rd_en"}, 64'(rom_rd_en), 64'd0);
        check({tag, "_addr"}, 64'(rom_addr), 64'd0);
        check({tag, "_valid"}, 64'(window_valid), 64'd0);
        check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'd0);
        check_window({tag, "_window"}, 0, 1'b1);
    endtask

    // Drives a one-cycle fetch command and checks every cycle through the ack.
    task automatic run_fetch(input logic [1:0] c, input int row, input logic [1:0] exp_ack,
                             input logic exp_fd, input bit inject);
        int err_pulses;
        err_pulses = 0;
        @(negedge clk);
        cmd = c;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
`ifdef CONV_INPUT_IF_CMD_ERR_EN
            if (cmd_err) err_pulses++;
`endif
            if (n == 1) cmd = 2'd0;
            if (inject && n == 3) cmd = 2'd2;
            if (inject && n == 4) cmd = 2'd0;
            check("rd_en", 64'(rom_rd_en), (n <= IS) ? 64'd1 : 64'd0);
            if (n <= IS) check("addr", 64'(rom_addr), 64'(row * IS + n - 1));
            check("ack", 64'(ack), (n == 10) ? 64'(exp_ack) : 64'd0);
            if (n == 1) begin
                check("frame_done", 64'(frame_done), 64'(exp_fd));
                check("valid_fetch", 64'(window_valid), 64'd0);
            end
            if (n == 2) check("frame_done_end", 64'(frame_done), 64'd0);
            if (n == 10) begin
                check("valid_done", 64'(window_valid), 64'd1);
                check_window("window_row", row * IS, 1'b0);
            end
            if (n == 11) check("state_idle", 64'(dbg_state), 64'd0);
        end
`ifdef CONV_INPUT_IF_CMD_ERR_EN
        check("cmd_err_pulses", 64'(err_pulses), inject ? 64'd1 : 64'd0);
`endif
    endtask

    task automatic run_shift(input int base, input bit zero, input logic exp_valid);
        @(negedge clk);
        cmd = 2'd2;
        @(negedge clk);
        cmd = 2'd0;
        check("shift_ack", 64'(ack), 64'd2);
        check("shift_valid", 64'(window_valid), 64'(exp_valid));
        check_window("shift_window", base, zero);
        @(negedge clk);
        check("shift_ack_end", 64'(ack), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("post_reset");

        // Shift with an empty buffer is still acknowledged.
        run_shift(0, 1'b1, 1'b0);

        run_fetch(2'd1, 0, 2'd1, 1'b0, 1'b0);

        run_shift(1, 1'b0, 1'b1);
        run_shift(2, 1'b0, 1'b1);
        run_shift(0, 1'b0, 1'b1);

        for (int r = 1; r < IS; r++) begin
            run_fetch(2'd3, r, 2'd3, 1'b0, 1'b0);
        end
        run_fetch(2'd3, 0, 2'd3, 1'b1, 1'b0);

        // Shift arriving mid-fetch must be ignored.
        run_fetch(2'd1, 0, 2'd1, 1'b0, 1'b1);

        // Reset in the middle of a preload.
        @(negedge clk);
        cmd = 2'd1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) cmd = 2'd0;
        end
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("mid_reset_ack", 64'(ack), 64'd0);
        end
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check("after_reset_ack", 64'(ack), 64'd0);
        end
        run_fetch(2'd1, 0, 2'd1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_input_interface.md
# conv_input_interface

Responder side of the convolution layer's input command/ack protocol. It receives 2-bit commands from the conv layer controller, fetches image rows from the image ROM into a row buffer, and presents an ARRAY_SIZE-wide pixel window to the kernel array. It answers each completed command with a one-cycle 2-bit acknowledge. It sits between the image ROM and the kernel array, under the controller.

## Interface
- WIDTH, 32, pixel width in bits
- KERNEL_SIZE, 3, kernel edge; number of distinct window offsets
- IMAGE_SIZE, 8, image edge; row length in pixels and number of rows
- ARRAY_SIZE, 6, window width; must equal IMAGE_SIZE-KERNEL_SIZE+1
- ADDR_WIDTH, 6, ROM address width; ROM_DEPTH = IMAGE_SIZE*IMAGE_SIZE = 64
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- input_interface_cmd  in  2  command code: IDLE=0, PRELOAD_START=1, SHIFT_START=2, LOAD_START=3
- input_interface_ack  out  2  acknowledge code: IDLE=0, PRELOAD_FIN=1, SHIFT_FIN=2, LOAD_FIN=3
- rom_rd_en  out  1  ROM read strobe
- rom_addr  out  ADDR_WIDTH  ROM address, row-major (row*IMAGE_SIZE+col)
- rom_data  in  WIDTH  ROM read data, valid 1 cycle after rom_rd_en
- window_data  out  ARRAY_SIZE*WIDTH  pixel i at bits [i*WIDTH +: WIDTH] = buf[offset+i]
- window_valid  out  1  buffer holds a complete row and no fetch is in progress
- frame_done  out  1  one-cycle pulse when LOAD_START wraps from last row to row 0

## Operation
- FSM states: S_IDLE, S_FETCH, S_DRAIN, S_ACK.
- Commands are sampled only in S_IDLE. Non-IDLE codes in any other state are ignored.
- PRELOAD_START:
  - row <= 0, offset <= 0, then S_FETCH.
  - S_FETCH issues IMAGE_SIZE reads at row*IMAGE_SIZE + col, col = 0..IMAGE_SIZE-1, one per cycle.
  - Each returning word is written to buf[col] one cycle after its read (pipelined col register).
  - After the last read, go to S_DRAIN for one cycle to capture the final word, then S_ACK.
  - S_ACK drives PRELOAD_FIN, then returns to S_IDLE.
- SHIFT_START:
  - offset <= (offset == KERNEL_SIZE-1) ? 0 : offset+1; buffer contents unchanged.
  - Go directly to S_ACK, which drives SHIFT_FIN.
- LOAD_START:
  - row <= (row == IMAGE_SIZE-1) ? 0 : row+1; offset <= 0; then the fetch sequence as for preload, ending with LOAD_FIN.
  - On the wrap to row 0, frame_done pulses in the cycle LOAD_START is accepted.
- SHIFT_START before any PRELOAD (buffer never filled) is still acknowledged. window_data is then the reset contents (zeros).
- window_valid: cleared on entering S_FETCH; set in S_ACK when the row was fetched; stays set across shifts.
- Arithmetic: row and offset are unsigned, $clog2 widths; ROM address = row*IMAGE_SIZE + col, truncated to ADDR_WIDTH. No overflow occurs with legal parameters.

## Timing
- Reset values: ack=0, rom_rd_en=0, rom_addr=0, window_data=0 (buffer cleared), window_valid=0, frame_done=0, state=S_IDLE, row=0, offset=0.
- The command is seen at clock edge T (state S_IDLE).
- PRELOAD/LOAD:
  - rom_rd_en is high for cycles T+1..T+IMAGE_SIZE.
  - The last word is captured at T+IMAGE_SIZE+1.
  - ack is high for one cycle at T+IMAGE_SIZE+2 (10 cycles with defaults).
- SHIFT: ack is high for one cycle at T+1.
- The next command is accepted at the edge after the ack cycle. A command held constant across ack is therefore re-executed, so the controller must drive a one-cycle pulse.
- ack and window_data are registered outputs. window_data reflects a new offset in the same cycle the SHIFT_FIN ack is high.
- Reset mid-fetch aborts immediately: all reset values apply and no ack is issued.

## Configuration
- CONV_INPUT_IF_CMD_ERR_EN:
  - Defined: adds output cmd_err (1 bit, reset 0). It pulses one cycle when a non-IDLE command arrives outside S_IDLE, or when SHIFT_START/LOAD_START arrives before the first PRELOAD.
  - Not defined: the port is absent, and such commands are ignored silently (or executed, per Operation).

## Structure
- Shared package conv_layer_pkg: the CMD_* and ACK_* codes, the FSM state encoding, and default geometry constants (WIDTH, KERNEL_SIZE, IMAGE_SIZE, ARRAY_SIZE, ADDR_WIDTH).
- One sub-module, conv_row_buffer: holds IMAGE_SIZE x WIDTH storage with a write port (col, data, we) and the offset-indexed ARRAY_SIZE window mux. The FSM, address generation and ack logic stay in conv_input_interface.

## Test plan
- ROM word = address. PRELOAD pulse at T -> rom_rd_en high T+1..T+8 with addresses 0..7; ack=1 exactly at T+10; window = 0..5; window_valid=1.
- After preload, two SHIFT pulses -> each ack=2 one cycle after its pulse; windows 1..6 then 2..7; a third SHIFT wraps the window back to 0..5.
- LOAD pulse x7 after preload -> rows 1..7 fetched (row 7 window = 56..61) with ack=3. An 8th LOAD reads 0..7 with frame_done pulsed.
- SHIFT pulse issued mid-fetch -> ignored; the only ack is PRELOAD_FIN at T+10. With CONV_INPUT_IF_CMD_ERR_EN defined, cmd_err pulses once.
- rst_n low at T+4 of a preload -> outputs at reset values, no ack. A fresh preload then completes normally with window 0..5.
- SHIFT before any preload -> ack=2 at T+1; window all zero; window_valid=0.
